// File: rtl/chip8_keypad_events.sv
// chip8_keypad_events: debounced CHIP-8 key state plus the FX0A wait-for-key handshake.
// Build option: CHIP8_WAIT_RELEASE_EN completes a wait on release of the chosen key; otherwise on press.
//
// state | meaning
// IDLE  | no wait in progress
// ARMED | wait requested, looking for a fresh key press
// HELD  | key chosen, waiting for its release (release build only)
// DONE  | key_valid_out pulse, back to IDLE next cycle
module chip8_keypad_events #(
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [15:0] key_raw_in,
   output logic [15:0] key_state_out,
   input  logic        wait_req_in,
   input  logic        wait_cancel_in,
   output logic        wait_busy_out,
   output logic        key_valid_out,
   output logic [3:0]  key_idx_out
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] TICK_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ARMED, HELD, DONE} state_t;

   logic [CW-1:0]      tick_cnt_q, tick_cnt_d;
   logic               tick;
   logic [15:0][2:0]   hist_q, hist_d;
   logic [15:0]        key_state_q, key_state_d;
   logic [15:0]        prev_state_q;
   logic [15:0]        rise;
   logic [3:0]         low_idx;
   logic [3:0]         key_idx_q, key_idx_d;
   state_t             state_q, state_d;

   assign tick       = (tick_cnt_q == TICK_LAST);
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);

   // The key state follows the history only once all three samples agree.
   always_comb begin
      hist_d      = hist_q;
      key_state_d = key_state_q;
      for (int n = 0; n < 16; n++) begin
         if (tick) hist_d[n] = {hist_q[n][1:0], key_raw_in[n]};
         if (hist_d[n] == 3'b111)      key_state_d[n] = 1'b1;
         else if (hist_d[n] == 3'b000) key_state_d[n] = 1'b0;
      end
   end

   assign rise = key_state_q & ~prev_state_q;

   always_comb begin
      low_idx = '0;
      for (int n = 15; n >= 0; n--) begin
         if (rise[n]) low_idx = 4'(n);
      end
   end

   always_comb begin
      state_d   = state_q;
      key_idx_d = key_idx_q;
      if (wait_cancel_in) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (wait_req_in) state_d = ARMED;
            ARMED: begin
               if (rise != '0) begin
                  key_idx_d = low_idx;
`ifdef CHIP8_WAIT_RELEASE_EN
                  state_d   = HELD;
`else
                  state_d   = DONE;
`endif
               end
            end
`ifdef CHIP8_WAIT_RELEASE_EN
            HELD: if (!key_state_q[key_idx_q]) state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         tick_cnt_q   <= '0;
         hist_q       <= '0;
         key_state_q  <= '0;
         prev_state_q <= '0;
         key_idx_q    <= '0;
         state_q      <= IDLE;
      end else begin
         tick_cnt_q   <= tick_cnt_d;
         hist_q       <= hist_d;
         key_state_q  <= key_state_d;
         prev_state_q <= key_state_q;
         key_idx_q    <= key_idx_d;
         state_q      <= state_d;
      end
   end

   assign key_state_out = key_state_q;
   assign key_idx_out   = key_idx_q;
   assign wait_busy_out = (state_q != IDLE);
   assign key_valid_out = (state_q == DONE);

endmodule
